// File: rtl/iir_fixed_pkg.sv
// Shared fixed-point definitions for the IIR filter datapath.
//  - default single-width operand format (INT_BITS.FRAC_BITS)
//  - calc_w(): width of a double-width signed product (2*(I+F)+1)
//  - saturation limits for the default product width
//  - add/sub op encoding used on the in_op port
package iir_fixed_pkg;

  localparam int INT_BITS_DEF  = 12;
  localparam int FRAC_BITS_DEF = 16;

  function automatic int calc_w(input int int_bits, input int frac_bits);
    return 2 * (int_bits + frac_bits) + 1;
  endfunction

  localparam int W_DEF = calc_w(INT_BITS_DEF, FRAC_BITS_DEF);

  localparam logic [W_DEF-1:0] MAX_POS = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic [W_DEF-1:0] MAX_NEG = {1'b1, {(W_DEF-1){1'b0}}};

  typedef enum logic {
    OP_SUB = 1'b0,
    OP_ADD = 1'b1
  } op_e;

endpackage

// File: rtl/iir_skid_buf.sv
// Two-entry fall-through skid buffer with a registered ready.
//  When empty and the consumer is ready, input data passes straight through
//  (no added latency); otherwise beats queue in a 2-deep ring.
//  o_ready is a flop: it drops only when both entries will be occupied.
// Ports:
//  clk, rst           clock, synchronous active-high reset
//  i_valid/o_ready    upstream handshake
//  i_data  [DW]       upstream payload
//  o_valid/i_ready    downstream handshake
//  o_data  [DW]       downstream payload (head entry or bypass)
module iir_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_cnt;
  logic          r_ready;

  logic       w_push;
  logic       w_empty;
  logic       w_pop;
  logic       w_wr;
  logic       w_rd;
  logic [1:0] w_cnt_nxt;

  assign w_push  = i_valid & r_ready;
  assign w_empty = (r_cnt == 2'd0);
  assign o_valid = !w_empty | w_push;
  assign o_data  = w_empty ? i_data : r_mem[r_rd_ptr];
  assign w_pop   = o_valid & i_ready;
  // bypassed beats never touch storage
  assign w_wr    = w_push & !(w_empty & w_pop);
  assign w_rd    = w_pop & !w_empty;
  assign w_cnt_nxt = r_cnt + {1'b0, w_wr} - {1'b0, w_rd};
  assign o_ready = r_ready;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= ~r_wr_ptr;
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/iir_addsub_pipe.sv
// Pipelined signed add/subtract for the IIR biquad datapath.
//  skid (2) -> S1: exact W+1-bit a+b / a-b -> S2: saturate or wrap to W, output regs.
//  Latency 2 cycles from accept to out_valid, 1 beat/clk, 4 beats in flight max.
//  in_ready is low exactly when all 4 slots hold a beat (skid full implies S1/S2 full).
// Configuration macro: IIR_ADDSUB_SATURATE_EN
//  defined   : clamp to [-2^(W-1), 2^(W-1)-1], flag out_ovf, keep ovf_sticky
//  undefined : two's-complement wrap, out_ovf/ovf_sticky tied 0, ovf_clear ignored
// Ports:
//  clk, rst                         clock, synchronous active-high reset
//  in_valid/in_ready                input handshake (in_ready registered)
//  in_op, in_a, in_b, in_tag        op (0 sub, 1 add), operands, pass-through tag
//  out_valid/out_ready              output handshake
//  out_res, out_tag, out_ovf        result, tag, per-beat saturation flag
//  ovf_sticky, ovf_clear            sticky saturation flag and its clear
module iir_addsub_pipe
  import iir_fixed_pkg::*;
#(
  parameter  int INT_BITS  = INT_BITS_DEF,
  parameter  int FRAC_BITS = FRAC_BITS_DEF,
  parameter  int TAG_W     = 4,
  localparam int W         = calc_w(INT_BITS, FRAC_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clear
);

  localparam int DW = 1 + 2*W + TAG_W;

  // ---------------- input skid ----------------
  logic [DW-1:0]    w_in_pkt;
  logic [DW-1:0]    w_sk_pkt;
  logic             w_sk_valid;
  logic             w_s1_ready;
  logic             w_s2_ready;

  assign w_in_pkt = {in_op, in_a, in_b, in_tag};

  iir_skid_buf #(.DW(DW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_pkt),
    .o_valid (w_sk_valid),
    .i_ready (w_s1_ready),
    .o_data  (w_sk_pkt)
  );

  logic             w_op;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [TAG_W-1:0] w_tag;
  logic [W:0]       w_a_x;
  logic [W:0]       w_b_x;
  logic [W:0]       w_sum;

  assign {w_op, w_a, w_b, w_tag} = w_sk_pkt;
  assign w_a_x = {w_a[W-1], w_a};
  assign w_b_x = {w_b[W-1], w_b};
  assign w_sum = (w_op == OP_ADD) ? (w_a_x + w_b_x) : (w_a_x - w_b_x);

  // ---------------- S1: exact sum ----------------
  logic             r_s1_vld;
  logic [W:0]       r_s1_sum;
  logic [TAG_W-1:0] r_s1_tag;

  assign w_s2_ready = !out_valid | out_ready;
  assign w_s1_ready = !r_s1_vld | w_s2_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_sum <= '0;
      r_s1_tag <= '0;
    end else if (w_s1_ready) begin
      r_s1_vld <= w_sk_valid;
      if (w_sk_valid) begin
        r_s1_sum <= w_sum;
        r_s1_tag <= w_tag;
      end
    end
  end

  // ---------------- S2: narrow to W ----------------
  logic [W-1:0] w_s2_res;
  logic         w_s2_ovf;

`ifdef IIR_ADDSUB_SATURATE_EN
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  // top two bits of the W+1 result disagree -> value outside W-bit range
  always_comb begin
    w_s2_res = r_s1_sum[W-1:0];
    w_s2_ovf = 1'b0;
    if (r_s1_sum[W] != r_s1_sum[W-1]) begin
      w_s2_ovf = 1'b1;
      w_s2_res = r_s1_sum[W] ? SAT_NEG : SAT_POS;
    end
  end
`else
  assign w_s2_res = r_s1_sum[W-1:0];
  assign w_s2_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
    end else if (w_s2_ready) begin
      out_valid <= r_s1_vld;
      if (r_s1_vld) begin
        out_res <= w_s2_res;
        out_tag <= r_s1_tag;
        out_ovf <= w_s2_ovf;
      end
    end
  end

  // ---------------- sticky flag ----------------
`ifdef IIR_ADDSUB_SATURATE_EN
  logic r_ovf_sticky;

  // set on output transfer of a saturated beat; set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)                                  r_ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && out_ovf) r_ovf_sticky <= 1'b1;
    else if (ovf_clear)                       r_ovf_sticky <= 1'b0;
  end

  assign ovf_sticky = r_ovf_sticky;
`else
  logic w_unused;
  assign w_unused   = ^{ovf_clear, r_s1_sum[W]};
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_iir_addsub_pipe.sv
module tb_iir_addsub_pipe;

  localparam int W  = 57;
  localparam int TW = 4;

`ifdef IIR_ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [W-1:0] P57 = {1'b0, {56{1'b1}}};
  localparam logic [W-1:0] N57 = {1'b1, {56{1'b0}}};
  localparam longint MAXP = 64'sh00FF_FFFF_FFFF_FFFF;   //  2^56-1
  localparam longint MAXN = -64'sh0100_0000_0000_0000;  // -2^56

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_op = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_res;
  logic [TW-1:0] out_tag;
  logic          out_ovf;
  logic          ovf_sticky;
  logic          ovf_clear = 1'b0;

  iir_addsub_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          ovf;
  } exp_t;

  exp_t q[$];          // accepted, not yet delivered beats (expected results)
  int   seen[$];       // tags of delivered beats
  logic m_sticky = 1'b0;
  logic prev_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: exact integer result of a op b, then clamp or wrap to 57 bits.
  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] tg);
    exp_t   e;
    longint sa, sb, r, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = op ? (sa + sb) : (sa - sb);
    e.tag = tg;
    e.ovf = 1'b0;
    e.res = r[W-1:0];
    if (SAT && r > MAXP) begin t = MAXP; e.res = t[W-1:0]; e.ovf = 1'b1; end
    if (SAT && r < MAXN) begin t = MAXN; e.res = t[W-1:0]; e.ovf = 1'b1; end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd57();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       return x[W-1:0];
      1:       return P57 - W'($urandom_range(0, 8));
      2:       return N57 + W'($urandom_range(0, 8));
      default: return W'($signed(x[15:0]));
    endcase
  endfunction

  // One clock: check state at the negedge, drive the next inputs, update the model
  // with whatever transfers the coming posedge will perform.
  task automatic step(input logic r, input logic v, input logic op,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tg,
                      input logic ordy, input logic clr, output logic acc);
    logic oxf, set;
    exp_t e;
    @(negedge clk);
    if (prev_rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_res", out_res, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_ovf_sticky", ovf_sticky, 0);
    end else begin
      chk("in_ready", in_ready, (q.size() < 4));
      chk("ovf_sticky", ovf_sticky, m_sticky);
      if (out_valid) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL stale_beat: out_valid=1 tag=%0d with no beat outstanding", out_tag);
        end else begin
          chk("out_res", out_res, q[0].res);
          chk("out_tag", out_tag, q[0].tag);
          chk("out_ovf", out_ovf, q[0].ovf);
        end
      end
    end
    rst = r; in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tg;
    out_ready = ordy; ovf_clear = clr;
    acc = v & in_ready & !r;
    oxf = out_valid & ordy & !r;
    if (r) begin
      q.delete();
      m_sticky = 1'b0;
    end else begin
      set = 1'b0;
      if (oxf && q.size() > 0) begin
        e = q.pop_front();
        set = e.ovf;
        seen.push_back(int'(out_tag));
      end
      if (acc) q.push_back(model(op, a, b, tg));
      m_sticky = set | (m_sticky & !clr);
    end
    prev_rst = r;
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic acc;
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, clr, acc);
  endtask

  // Single beat into an empty pipe, literal checks on latency and result.
  task automatic run_one(input string nm, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tg,
                         input logic [W-1:0] xres, input logic xovf, input logic clr_last);
    logic acc;
    step(1'b0, 1'b1, op, a, b, tg, 1'b1, 1'b0, acc);
    chk({nm, "_accept"}, acc, 1);
    idle(1'b1, 1'b0);
    chk({nm, "_valid_c1"}, out_valid, 0);
    idle(1'b1, clr_last);
    chk({nm, "_valid_c2"}, out_valid, 1);
    chk({nm, "_res"}, out_res, xres);
    chk({nm, "_tag"}, out_tag, tg);
    chk({nm, "_ovf"}, out_ovf, xovf);
  endtask

  initial begin
    logic acc;
    int   n_acc, t, sent;
    logic v, op;
    logic [W-1:0] a, b;
    logic [TW-1:0] tg;

    step(1'b1, 0, 0, '0, '0, '0, 0, 0, acc);
    step(1'b1, 0, 0, '0, '0, '0, 0, 0, acc);
    idle(1'b1, 1'b0);
    chk("ready_after_reset", in_ready, 0);
    idle(1'b1, 1'b0);
    chk("ready_first_cycle_after", in_ready, 1);

    // 1/2/3: directed arithmetic
    run_one("t1_sub", 1'b0, W'(5), W'(3), 4'hA, W'(2), 1'b0, 1'b0);
    run_one("t2_add", 1'b1, -57'sd7, W'(4), 4'h3, -57'sd3, 1'b0, 1'b0);
    run_one("t2_neg", 1'b0, N57, W'(1), 4'h5, SAT ? N57 : P57, SAT, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("t2_sticky_cleared", ovf_sticky, 0);
    // saturating beat leaves in the same cycle as a clear: set must win
    run_one("t3_pos", 1'b0, P57, {W{1'b1}}, 4'h6, SAT ? P57 : N57, SAT, 1'b1);
    idle(1'b1, 1'b0);
    chk("t3_sticky_set_wins", ovf_sticky, SAT);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("t3_sticky_clear", ovf_sticky, 0);

    // 4: back-pressure, capacity 4, order preserved
    seen.delete();
    n_acc = 0;
    for (int tt = 0; tt < 6; tt++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd57(), rnd57(), TW'(tt), 1'b0, 1'b0, acc);
        if (acc) begin n_acc++; break; end
      end
    end
    idle(1'b0, 1'b0);
    chk("t4_accepted", n_acc, 4);
    chk("t4_in_ready_low", in_ready, 0);
    chk("t4_out_valid_held", out_valid, 1);
    chk("t4_out_tag_held", out_tag, 0);
    t = 4;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, (t < 6), 1'b1, rnd57(), rnd57(), TW'(t), 1'b1, 1'b0, acc);
      if (acc) t++;
    end
    chk("t4_delivered", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) chk("t4_order", seen[i], i);

    // 5: random traffic
    sent = 0;
    op = 1'($urandom_range(0, 1)); a = rnd57(); b = rnd57(); tg = TW'($urandom);
    for (int cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
      v = ($urandom_range(0, 4) != 0);
      step(1'b0, v, op, a, b, tg, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), acc);
      if (acc) begin
        sent++;
        op = 1'($urandom_range(0, 1)); a = rnd57(); b = rnd57(); tg = TW'($urandom);
      end
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) idle(1'b1, 1'b0);
    chk("t5_sent", sent, 10000);
    chk("t5_drained", q.size(), 0);

    // 6: reset with beats in flight
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, P57, {W{1'b1}}, TW'(k), 1'b0, 1'b0, acc);
      chk("t6_accept", acc, 1);
    end
    step(1'b1, 0, 0, '0, '0, '0, 0, 0, acc);
    seen.delete();
    idle(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) idle(1'b1, 1'b0);
    chk("t6_nothing_emitted", seen.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
